// File: rtl/cluster_frame_scheduler.sv
// rtl/cluster_frame_scheduler.sv - per-BX frame sequencer: count alignment, descriptor FIFO, link framing
// Frames are header + min(count,MAX_CLUSTERS) packer words on a valid/ready link.
module cluster_frame_scheduler #(
  parameter int CNT_LATENCY  = 5,
  parameter int MAX_CLUSTERS = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clock4x,
  input  logic        reset,
  input  logic        bx_strobe,
  input  logic [7:0]  cnt_in,
  input  logic [13:0] clst_data,
  input  logic        clst_valid,
  output logic        clst_ready,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_sof,
  output logic        out_eof,
  output logic [15:0] drop_cnt,
  output logic [15:0] ovf_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [7:0] MAX_CNT = 8'(MAX_CLUSTERS);

  typedef enum logic [1:0] {IDLE, HEADER, CLUSTERS} state_t;
  state_t state, state_nxt;

  logic [CNT_LATENCY-1:0] strb_sr;
  logic                   strb_d;
  logic [9:0]             bxid;
  logic                   ovf_now;
  logic [3:0]             n_now;

  logic [14:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   fifo_cnt;
  logic          fifo_full, fifo_empty, push, pop;

  logic [9:0] cur_bxid;
  logic [3:0] cur_n;
  logic       cur_ovf;
  logic [3:0] remaining;

  assign strb_d     = strb_sr[CNT_LATENCY-1];
  assign ovf_now    = cnt_in > MAX_CNT;
  assign n_now      = ovf_now ? MAX_CNT[3:0] : cnt_in[3:0];
  assign fifo_full  = fifo_cnt == (AW+1)'(FIFO_DEPTH);
  assign fifo_empty = fifo_cnt == '0;
  // Fullness is judged on the pre-pop occupancy, so a same-cycle pop cannot rescue a strobe.
  assign push       = strb_d && !fifo_full;

  always_ff @(posedge clock4x or posedge reset) begin
    if (reset) begin
      strb_sr  <= '0;
      bxid     <= '0;
      drop_cnt <= '0;
      ovf_cnt  <= '0;
    end else begin
      strb_sr <= (strb_sr << 1) | CNT_LATENCY'(bx_strobe);
      if (strb_d) begin
        bxid <= bxid + 10'd1;
        if (fifo_full && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
        if (ovf_now && ovf_cnt != 16'hFFFF) ovf_cnt <= ovf_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge clock4x) begin
    if (push) fifo_mem[wr_ptr] <= {bxid, n_now, ovf_now};
  end

  always_ff @(posedge clock4x or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop) fifo_cnt <= fifo_cnt + (AW+1)'(1);
      else if (pop && !push) fifo_cnt <= fifo_cnt - (AW+1)'(1);
    end
  end

  always_ff @(posedge clock4x or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cur_bxid  <= '0;
      cur_n     <= '0;
      cur_ovf   <= 1'b0;
      remaining <= '0;
    end else begin
      state <= state_nxt;
      if (pop) begin
        {cur_bxid, cur_n, cur_ovf} <= fifo_mem[rd_ptr];
        remaining                  <= fifo_mem[rd_ptr][4:1];
      end else if (state == CLUSTERS && clst_valid && out_ready) begin
        remaining <= remaining - 4'd1;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    pop        = 1'b0;
    out_valid  = 1'b0;
    out_sof    = 1'b0;
    out_eof    = 1'b0;
    out_data   = '0;
    clst_ready = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = HEADER;
        end
      end
      HEADER: begin
        out_valid = 1'b1;
        out_sof   = 1'b1;
        out_eof   = cur_n == 4'd0;
        out_data  = {1'b1, cur_ovf, cur_n, cur_bxid};
        if (out_ready) state_nxt = (cur_n == 4'd0) ? IDLE : CLUSTERS;
      end
      CLUSTERS: begin
        clst_ready = out_ready;
        out_valid  = clst_valid;
        if (clst_valid) begin
          out_data = {2'b00, clst_data};
          out_eof  = remaining == 4'd1;
        end
        if (clst_valid && out_ready && remaining == 4'd1) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_cluster_frame_scheduler.sv
// tb/tb_cluster_frame_scheduler.sv - scoreboard bench for cluster_frame_scheduler
module tb_cluster_frame_scheduler;
  localparam int LAT = 5, MAXC = 8, DEPTH = 4;

  logic        clock4x = 1'b0;
  logic        reset = 1'b1;
  logic        bx_strobe = 1'b0;
  logic [7:0]  cnt_in = '0;
  logic [13:0] clst_data = '0;
  logic        clst_valid = 1'b0;
  logic        clst_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_sof, out_eof;
  logic [15:0] drop_cnt, ovf_cnt;

  always #5 clock4x = ~clock4x;

  cluster_frame_scheduler #(.CNT_LATENCY(LAT), .MAX_CLUSTERS(MAXC), .FIFO_DEPTH(DEPTH)) dut (
    .clock4x(clock4x), .reset(reset), .bx_strobe(bx_strobe), .cnt_in(cnt_in),
    .clst_data(clst_data), .clst_valid(clst_valid), .clst_ready(clst_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_sof(out_sof), .out_eof(out_eof), .drop_cnt(drop_cnt), .ovf_cnt(ovf_cnt)
  );

  typedef struct {int bxid; int n; int ovf;} frame_t;
  frame_t exp_q[$];
  int     strb_q[$];
  int     cyc = 0, n_push = 0, n_pop = 0, bxid_m = 0, exp_drop = 0, exp_ovf = 0;
  int     checks = 0, errors = 0;
  int     cnt_fix = 0, vmode = 0, rmode = 0;
  int     words_left = 0, hdr_first_cyc = -1, last_eof_cyc = -1;
  bit     in_cl = 0, hdr_held = 0;
  logic [15:0] held_word = '0, last_hdr = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 'h%0h expected 'h%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got 'h%0h, nothing expected (cycle %0d)", name, act, cyc);
  endtask

  // Reference model: descriptor formed LAT cycles after each strobe, queue bounded by DEPTH.
  always @(posedge clock4x) begin
    if (reset) begin
      strb_q.delete();
      n_push = 0; bxid_m = 0; exp_drop = 0; exp_ovf = 0;
    end else if (strb_q.size() > 0 && strb_q[0] + LAT == cyc) begin
      int n, ovf;
      void'(strb_q.pop_front());
      ovf = (int'(cnt_in) > MAXC) ? 1 : 0;
      n   = ovf ? MAXC : int'(cnt_in);
      if (ovf) exp_ovf++;
      if (n_push - n_pop >= DEPTH) exp_drop++;
      else begin
        exp_q.push_back('{bxid_m, n, ovf});
        n_push++;
      end
      bxid_m = (bxid_m + 1) % 1024;
    end
    cyc++;
  end

  always @(posedge clock4x) begin
    #1;
    cnt_in    = (cnt_fix >= 0) ? 8'(cnt_fix) : 8'($urandom_range(0, 15));
    clst_data = 14'($urandom);
    case (vmode)
      0:       clst_valid = 1'b1;
      1:       clst_valid = ~clst_valid;
      default: clst_valid = $urandom_range(0, 9) < 7;
    endcase
    out_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  // Monitor: pops expected frames when headers appear and checks every presented word.
  always @(negedge clock4x) begin
    if (reset) begin
      words_left = 0; in_cl = 0; hdr_held = 0; n_pop = 0;
      exp_q.delete();
      check("reset_outputs", {out_valid, out_sof, out_eof, clst_ready, out_data, drop_cnt, ovf_cnt}, 0);
    end else begin
      check("clst_ready", clst_ready, in_cl && out_ready);
      if (in_cl) check("valid_mirror", out_valid, clst_valid);
      if (!out_valid) begin
        check("idle_zero", {out_sof, out_eof, out_data}, 0);
      end else if (out_sof) begin
        if (in_cl) fail("sof_in_clusters", out_data);
        if (hdr_held) check("hdr_hold", out_data, held_word);
        else begin
          n_pop++;
          hdr_first_cyc = cyc;
          last_hdr = out_data;
          if (exp_q.size() == 0) begin
            fail("unexpected_header", out_data);
            words_left = 0;
          end else begin
            frame_t e;
            logic [15:0] eh;
            e  = exp_q.pop_front();
            eh = {1'b1, 1'(e.ovf), 4'(e.n), 10'(e.bxid)};
            check("hdr_data", out_data, eh);
            words_left = e.n;
          end
        end
        check("hdr_eof", out_eof, words_left == 0);
        held_word = out_data;
        hdr_held  = !out_ready;
        if (out_ready) begin
          in_cl = words_left > 0;
          if (words_left == 0) last_eof_cyc = cyc;
        end
      end else if (!in_cl) begin
        fail("stray_word", out_data);
      end else begin
        check("clst_data", out_data, {2'b00, clst_data});
        check("clst_eof", out_eof, words_left == 1);
        if (out_ready) begin
          words_left--;
          if (words_left == 0) begin
            in_cl = 0;
            last_eof_cyc = cyc;
          end
        end
      end
    end
  end

  task automatic tick(input bit s);
    @(posedge clock4x);
    #1;
    bx_strobe = s;
    if (s && !reset) strb_q.push_back(cyc);
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while ((exp_q.size() > 0 || strb_q.size() > 0 || in_cl || hdr_held) && k < budget) begin
      tick(0);
      k++;
    end
    if (k >= budget) fail("drain_timeout", k);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int s;
    repeat (3) tick(0);
    @(posedge clock4x);
    #1 reset = 1'b0;

    // single frame latency with free-flowing link
    cnt_fix = 3;
    tick(1);
    s = cyc;
    drain(100);
    check("t1_hdr_cycle", hdr_first_cyc, s + 7);
    check("t1_eof_cycle", last_eof_cyc, s + 10);
    check("t1_hdr_word", last_hdr, 16'h8C01 & 16'hFC00);

    cnt_fix = 0;
    tick(1);
    drain(100);
    check("t2_single_word", last_eof_cyc, hdr_first_cyc);
    check("t2_hdr_word", last_hdr, 16'h8001);

    cnt_fix = 12;
    tick(1);
    drain(100);
    check("t3_hdr_word", last_hdr, 16'hE002);
    check("t3_ovf_cnt", ovf_cnt, 1);

    // stalled link: one frame in HEADER, four queued, sixth strobe dropped
    cnt_fix = 1;
    rmode = 1;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      repeat (3) tick(0);
    end
    repeat (10) tick(0);
    check("t4_drop_cnt", drop_cnt, 1);
    check("t4_drop_model", drop_cnt, exp_drop);
    check("t4_queued", exp_q.size(), DEPTH);
    rmode = 0;
    drain(200);

    cnt_fix = 5;
    vmode = 1;
    tick(1);
    drain(100);
    vmode = 0;

    // randomized traffic with backpressure, gaps and close strobes
    cnt_fix = -1;
    vmode = 2;
    rmode = 2;
    for (int i = 0; i < 60; i++) begin
      tick(1);
      repeat ($urandom_range(0, 10)) tick(0);
    end
    repeat (LAT + 2) tick(0);
    rmode = 0;
    vmode = 0;
    drain(3000);
    check("rand_drop_cnt", drop_cnt, exp_drop);
    check("rand_ovf_cnt", ovf_cnt, exp_ovf);

    // reset in the middle of a cluster burst
    cnt_fix = 8;
    tick(1);
    s = 0;
    while (!in_cl && s < 30) begin
      tick(0);
      s++;
    end
    check("t6_in_clusters", in_cl, 1);
    check("t6_pre_valid", out_valid, 1);
    reset = 1'b1;
    #1;
    check("t6_outputs_zero", {out_valid, out_sof, out_eof, clst_ready, out_data}, 0);
    check("t6_counters_zero", {drop_cnt, ovf_cnt}, 0);
    repeat (2) tick(0);
    @(posedge clock4x);
    #1 reset = 1'b0;
    cnt_fix = 2;
    tick(1);
    drain(100);
    check("t6_bxid_restart", last_hdr, 16'h8800);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
